// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the router ports:
//   - flit layout: [19:18] dst_x, [17:16] dst_y, [15:0] payload
//   - one-hot route indices {W,S,E,N,L}
//   - xy_route(): dimension-ordered (X first) routing, reused by every port
// No ports (package).
// ---------------------------------------------------------------------------
package noc_pkg;

    localparam int FLIT_W    = 20;
    localparam int COORD_W   = 2;
    localparam int PAYLOAD_W = 16;

    // Field positions within a flit
    localparam int DST_X_MSB = FLIT_W - 1;
    localparam int DST_Y_MSB = FLIT_W - 1 - COORD_W;

    // One-hot route bit indices
    localparam int PORT_L    = 0;
    localparam int PORT_N    = 1;
    localparam int PORT_E    = 2;
    localparam int PORT_S    = 3;
    localparam int PORT_W    = 4;
    localparam int NUM_PORTS = 5;

    typedef logic [COORD_W-1:0]   coord_t;
    typedef logic [NUM_PORTS-1:0] route_t;
    typedef logic [FLIT_W-1:0]    flit_t;

    // X is resolved before Y; coordinates are unsigned, Y grows northward.
    function automatic route_t xy_route(
        input coord_t dst_x,
        input coord_t dst_y,
        input coord_t my_x,
        input coord_t my_y
    );
        route_t r;
        r = '0;
        if (dst_x > my_x) begin
            r[PORT_E] = 1'b1;
        end else if (dst_x < my_x) begin
            r[PORT_W] = 1'b1;
        end else if (dst_y > my_y) begin
            r[PORT_N] = 1'b1;
        end else if (dst_y < my_y) begin
            r[PORT_S] = 1'b1;
        end else begin
            r[PORT_L] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// ---------------------------------------------------------------------------
// noc_flit_fifo
// Circular flit buffer with read/write pointers and an occupancy counter.
// The head entry is read combinationally so a flit written at one edge is
// visible in the very next cycle.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en, wr_data    write request and flit
//   rd_en             pop request (ignored when empty)
//   rd_data           head flit (raw storage contents)
//   empty, full       occupancy status
//   pop_ok            a pop actually happens this cycle
//   drop              write refused: full and no simultaneous pop
// ---------------------------------------------------------------------------
module noc_flit_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = FLIT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full,
    output logic         pop_ok,
    output logic         drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W + 1)'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_DEPTH);
    assign pop_ok  = rd_en & ~empty;
    // A full buffer still accepts a flit when a slot frees up in the same cycle.
    assign push_ok = wr_en & (~full | pop_ok);
    assign drop    = wr_en & full & ~pop_ok;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; stale contents are never visible because
    // the top level masks the head while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/noc_local_inport.sv
// ---------------------------------------------------------------------------
// noc_local_inport
// Local input port of a router node: buffers flits from the PE, computes the
// XY route of the head flit, requests the crossbar and returns one credit
// per flit that leaves the buffer.
// Optional feature macro: NOC_INPORT_STATS_EN adds flit_cnt / ovf_cnt.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   datain, in_valid    flit from the PE
//   co                  credit pulse, one cycle after each pop
//   req, route          allocator request and one-hot {W,S,E,N,L} route
//   gnt                 allocator grant
//   dataout, out_valid  head flit and transfer strobe (req & gnt)
//   ovf                 sticky overflow flag
//   flit_cnt, ovf_cnt   (stats build only) pop count, saturating drop count
// ---------------------------------------------------------------------------
module noc_local_inport
    import noc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int MY_X  = 0,
    parameter int MY_Y  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] datain,
    input  logic              in_valid,
    output logic              co,
    output logic              req,
    output logic [4:0]        route,
    input  logic              gnt,
    output logic [FLIT_W-1:0] dataout,
    output logic              out_valid,
    output logic              ovf
`ifdef NOC_INPORT_STATS_EN
    ,
    output logic [15:0]       flit_cnt,
    output logic [7:0]        ovf_cnt
`endif
);

    localparam coord_t MY_XC = coord_t'(MY_X);
    localparam coord_t MY_YC = coord_t'(MY_Y);

    flit_t head;
    logic  empty;
    logic  full;
    logic  pop_ok;
    logic  drop;
    logic  co_q;
    logic  ovf_q, ovf_d;

    noc_flit_fifo #(
        .DEPTH (DEPTH),
        .W     (FLIT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (datain),
        .rd_en   (req & gnt),
        .rd_data (head),
        .empty   (empty),
        .full    (full),
        .pop_ok  (pop_ok),
        .drop    (drop)
    );

    assign req       = ~empty;
    assign out_valid = req & gnt;
    assign dataout   = req ? head : '0;
    assign route     = req ? xy_route(head[DST_X_MSB -: COORD_W],
                                      head[DST_Y_MSB -: COORD_W],
                                      MY_XC, MY_YC)
                           : '0;

    assign ovf_d = ovf_q | drop;

    // Credit is a delayed copy of the pop strobe; a reset cycle swallows it
    // because the upstream credit counter is reset at the same time.
    always_ff @(posedge clk) begin
        if (rst) begin
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            co_q  <= pop_ok;
            ovf_q <= ovf_d;
        end
    end

    assign co  = co_q;
    assign ovf = ovf_q;

`ifdef NOC_INPORT_STATS_EN
    logic [15:0] flit_cnt_q, flit_cnt_d;
    logic [7:0]  ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        flit_cnt_d = flit_cnt_q;
        ovf_cnt_d  = ovf_cnt_q;
        if (pop_ok) begin
            flit_cnt_d = flit_cnt_q + 16'd1;   // wraps naturally
        end
        if (drop && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flit_cnt_q <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            flit_cnt_q <= flit_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign flit_cnt = flit_cnt_q;
    assign ovf_cnt  = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_noc_local_inport.sv
// ---------------------------------------------------------------------------
// tb_noc_local_inport
// Directed bench for noc_local_inport with MY_X=1, MY_Y=1, DEPTH=8.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge, so combinational outputs reflect the current inputs.
// ---------------------------------------------------------------------------
module tb_noc_local_inport;

    logic        clk;
    logic        rst;
    logic [19:0] datain;
    logic        in_valid;
    logic        co;
    logic        req;
    logic [4:0]  route;
    logic        gnt;
    logic [19:0] dataout;
    logic        out_valid;
    logic        ovf;
`ifdef NOC_INPORT_STATS_EN
    logic [15:0] flit_cnt;
    logic [7:0]  ovf_cnt;
`endif

    int total;
    int bad;

    noc_local_inport #(
        .DEPTH (8),
        .MY_X  (1),
        .MY_Y  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .datain    (datain),
        .in_valid  (in_valid),
        .co        (co),
        .req       (req),
        .route     (route),
        .gnt       (gnt),
        .dataout   (dataout),
        .out_valid (out_valid),
        .ovf       (ovf)
`ifdef NOC_INPORT_STATS_EN
        ,
        .flit_cnt  (flit_cnt),
        .ovf_cnt   (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        gnt      = 1'b0;
        datain   = '0;
        adv();
        adv();
        rst = 1'b0;
    endtask

    // Push one flit, then grant it the following cycle and check its route.
    task automatic route_chk(input string tag, input logic [19:0] flit, input logic [4:0] exp_route);
        in_valid = 1'b1;
        datain   = flit;
        gnt      = 1'b0;
        adv();
        in_valid = 1'b0;
        gnt      = 1'b1;
        smp();
        chk({tag, "_route"}, 32'(route), 32'(exp_route));
        chk({tag, "_data"}, 32'(dataout), 32'(flit));
        adv();
        gnt = 1'b0;
    endtask

    initial begin
        logic [19:0] exp_q [$];
        int co_seen;
        total = 0;
        bad   = 0;

        // ---------------- reset values
        do_reset();
        smp();
        chk("rst_co", 32'(co), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_route", 32'(route), 32'd0);
        chk("rst_dataout", 32'(dataout), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        adv();

        // ---------------- single flit to (0,2) -> W, gnt held high
        in_valid = 1'b1;
        datain   = 20'h2ABCD;
        gnt      = 1'b1;
        smp();
        chk("t1_nobypass_req", 32'(req), 32'd0);
        chk("t1_nobypass_ov", 32'(out_valid), 32'd0);
        adv();
        in_valid = 1'b0;
        smp();
        chk("t1_req", 32'(req), 32'd1);
        chk("t1_route", 32'(route), 32'b10000);
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_dataout", 32'(dataout), 32'h2ABCD);
        chk("t1_co_early", 32'(co), 32'd0);
        adv();
        smp();
        chk("t1_co", 32'(co), 32'd1);
        chk("t1_req_after", 32'(req), 32'd0);
        adv();
        smp();
        chk("t1_co_once", 32'(co), 32'd0);
        adv();
        gnt = 1'b0;

        // ---------------- route sweep, MY=(1,1)
        route_chk("sw_E", 20'h90000, 5'b00100);   // (2,1)
        route_chk("sw_N", 20'h60000, 5'b00010);   // (1,2)
        route_chk("sw_S", 20'h40000, 5'b01000);   // (1,0)
        route_chk("sw_L", 20'h50000, 5'b00001);   // (1,1)
        route_chk("sw_W", 20'h11234, 5'b10000);   // (0,1)
        route_chk("sw_E33", 20'hF0001, 5'b00100); // (3,3): X wins

        // ---------------- fill, overflow, drain
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            datain   = 20'h50000 | 20'(i);
            adv();
        end
        smp();
        chk("ov_before", 32'(ovf), 32'd0);
        datain = 20'h5FFFF;               // 9th flit, buffer full
        adv();
        in_valid = 1'b0;
        smp();
        chk("ov_set", 32'(ovf), 32'd1);
        chk("ov_head", 32'(dataout), 32'h50000);
        adv();
        gnt     = 1'b1;
        co_seen = 0;
        for (int k = 0; k < 10; k++) begin
            smp();
            if (k < 8) begin
                chk($sformatf("ov_drain_v%0d", k), 32'(out_valid), 32'd1);
                chk($sformatf("ov_drain_d%0d", k), 32'(dataout), 32'h50000 | 32'(k));
            end else begin
                chk($sformatf("ov_drain_idle%0d", k), 32'(out_valid), 32'd0);
            end
            co_seen += int'(co);
            adv();
        end
        chk("ov_co_pulses", 32'(co_seen), 32'd8);
        smp();
        chk("ov_sticky", 32'(ovf), 32'd1);
        adv();
        gnt = 1'b0;

        // ---------------- full buffer with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            datain   = 20'h50100 | 20'(i);
            exp_q.push_back(20'h50100 | 20'(i));
            adv();
        end
        datain = 20'h50199;
        gnt    = 1'b1;
        exp_q.push_back(20'h50199);
        smp();
        chk("fp_out_valid", 32'(out_valid), 32'd1);
        chk("fp_dataout", 32'(dataout), 32'(exp_q.pop_front()));
        adv();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            smp();
            chk($sformatf("fp_drain_v%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("fp_drain_d%0d", k), 32'(dataout), 32'(exp_q.pop_front()));
            adv();
        end
        smp();
        chk("fp_empty", 32'(req), 32'd0);
        chk("fp_no_ovf", 32'(ovf), 32'd0);
        adv();
        gnt = 1'b0;

        // ---------------- reset with 3 flits buffered (pop pending in reset cycle)
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            datain   = 20'h50200 | 20'(i);
            adv();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        gnt      = 1'b1;
        adv();
        rst = 1'b0;
        smp();
        chk("mr_req", 32'(req), 32'd0);
        chk("mr_dataout", 32'(dataout), 32'd0);
        chk("mr_co", 32'(co), 32'd0);
        chk("mr_ovf", 32'(ovf), 32'd0);
        for (int k = 0; k < 3; k++) begin
            adv();
            smp();
            chk($sformatf("mr_stale_v%0d", k), 32'(out_valid), 32'd0);
            chk($sformatf("mr_stale_co%0d", k), 32'(co), 32'd0);
        end
        adv();
        gnt = 1'b0;

`ifdef NOC_INPORT_STATS_EN
        // ---------------- statistics counters
        begin
            int pops;
            do_reset();
            pops     = 0;
            gnt      = 1'b1;
            in_valid = 1'b1;
            datain   = 20'h50000;
            for (int n = 0; n < 70001; n++) begin
                smp();
                if (out_valid) pops++;
                adv();
            end
            in_valid = 1'b0;
            gnt      = 1'b0;
            smp();
            chk("st_pops", 32'(pops), 32'd70000);
            chk("st_flit_cnt", 32'(flit_cnt), 32'd4464);
            adv();
            do_reset();
            in_valid = 1'b1;
            for (int n = 0; n < 308; n++) begin
                adv();
            end
            in_valid = 1'b0;
            smp();
            chk("st_ovf_cnt", 32'(ovf_cnt), 32'd255);
            chk("st_flit_cnt_rst", 32'(flit_cnt), 32'd0);
            adv();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
